// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// logic_unit_arbiter : two-requester round-robin front end for a shared
//                      bitwise logic unit with a result-hold/ack handshake.
// Revision 1.0 : initial release
// ============================================================================
module logic_unit_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [1:0]       op0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [1:0]       op1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             result_id,
  output logic             zero_flag,
  output logic             busy,
  input  logic             ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_prio;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic             w_take;
  logic             w_win;
  logic [WIDTH-1:0] w_f;

  // On contention the requester matching prio wins; a lone requester always wins.
  assign w_take = req0 | req1;
  assign w_win  = (req0 & req1) ? r_prio : req1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_take) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = HOLD;
      HOLD:    if (ack) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_f = '0;
    case (r_op)
      2'b00:   w_f = r_a & r_b;
      2'b01:   w_f = r_a | r_b;
      2'b10:   w_f = r_a ^ r_b;
      default: w_f = ~r_a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio       <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= 2'b00;
      result       <= '0;
      result_valid <= 1'b0;
      result_id    <= 1'b0;
      zero_flag    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_a       <= w_win ? a1  : a0;
            r_b       <= w_win ? b1  : b0;
            r_op      <= w_win ? op1 : op0;
            result_id <= w_win;
            r_prio    <= ~w_win;
          end
        end
        EXEC: begin
          result       <= w_f;
          zero_flag    <= (w_f == '0);
          result_valid <= 1'b1;
        end
        HOLD: begin
          if (ack) begin
            result_valid <= 1'b0;
            zero_flag    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // The grant pulse is exactly the EXEC cycle, tagged by the captured owner.
  assign gnt0 = (r_state == EXEC) & ~result_id;
  assign gnt1 = (r_state == EXEC) &  result_id;
  assign busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// tb_logic_unit_arbiter : directed plus random traffic against a transaction-level
// reference model; results are checked from a scoreboard queue.
module tb_logic_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, ack = 1'b0;
  logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0]  op0 = '0, op1 = '0;
  logic        gnt0, gnt1, result_valid, result_id, zero_flag, busy;
  logic [15:0] result;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        id;
    logic [15:0] res;
  } txn_t;
  txn_t q[$];

  always #5 clk = ~clk;

  logic_unit_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .op0(op0),
    .req1(req1), .a1(a1), .b1(b1), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1),
    .result(result), .result_valid(result_valid), .result_id(result_id),
    .zero_flag(zero_flag), .busy(busy), .ack(ack)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lu(input logic [15:0] a, input logic [15:0] b,
                                     input logic [1:0] op);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // Reference model: the unit is either free or owned by one transaction.
  // A transaction's result appears one edge after acceptance and is released
  // by the first ack seen at a later edge.
  bit m_busy = 0, m_prio = 0;
  int m_age = 0;
  bit exp_gnt0 = 0, exp_gnt1 = 0, exp_valid = 0, exp_busy = 0;

  always @(posedge clk) begin
    bit w;
    exp_gnt0 = 0;
    exp_gnt1 = 0;
    if (rst) begin
      m_busy = 0; m_prio = 0; exp_valid = 0;
      q.delete();
    end else if (!m_busy) begin
      if (req0 || req1) begin
        w = (req0 && req1) ? m_prio : req1;
        q.push_back('{id: w, res: w ? lu(a1, b1, op1) : lu(a0, b0, op0)});
        m_prio = !w;
        m_busy = 1;
        m_age  = 0;
        if (w) exp_gnt1 = 1; else exp_gnt0 = 1;
      end
    end else begin
      m_age++;
      if (m_age == 1) exp_valid = 1;
      else if (ack) begin
        m_busy = 0;
        exp_valid = 0;
      end
    end
    exp_busy = m_busy;
  end

  // Monitor: cycle checks of handshake outputs and scoreboard pop on new results.
  logic        prev_valid = 0;
  logic [15:0] held_res;
  logic        held_id;
  always @(negedge clk) begin
    txn_t t;
    chk("gnt0", gnt0, exp_gnt0);
    chk("gnt1", gnt1, exp_gnt1);
    chk("busy", busy, exp_busy);
    chk("result_valid", result_valid, exp_valid);
    if (result_valid && !prev_valid) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_empty actual=result %h expected=no result", result);
      end else begin
        t = q.pop_front();
        chk("result", result, t.res);
        chk("result_id", result_id, t.id);
        chk("zero_flag", zero_flag, t.res == 16'h0);
      end
      held_res = result;
      held_id  = result_id;
    end else if (result_valid) begin
      chk("result_hold", result, held_res);
      chk("result_id_hold", result_id, held_id);
    end else begin
      chk("zero_flag_idle", zero_flag, 1'b0);
    end
    prev_valid = result_valid;
  end

  task automatic wait_gnt(input bit which);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = which ? gnt1 : gnt0;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL gnt_timeout actual=no gnt%0d expected=gnt%0d within 30 cycles", which, which);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    chk(name, {result, result_id, result_valid, zero_flag, busy, gnt0, gnt1},
        32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset_outputs");
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // AND transaction held until ack
    req0 = 1; a0 = 16'hF0F0; b0 = 16'hFF00; op0 = 2'b00;
    wait_gnt(0);
    req0 = 0;
    repeat (4) @(negedge clk);
    chk("and_result_held", {result_valid, result}, {1'b1, 16'hF000});
    ack = 1; @(negedge clk); ack = 0;

    // NOT with ack tied high
    req1 = 1; a1 = 16'h1234; b1 = 16'hFFFF; op1 = 2'b11; ack = 1;
    wait_gnt(1);
    req1 = 0;
    @(negedge clk);
    chk("not_result", result, 16'hEDCB);
    repeat (3) @(negedge clk);

    // Fairness from reset with both requests held
    do_reset();
    req0 = 1; req1 = 1; op0 = 2'b10; op1 = 2'b10;
    a0 = 16'hAAAA; b0 = 16'hAAAA; a1 = 16'h5555; b1 = 16'h0000;
    repeat (12) @(negedge clk);
    req0 = 0; req1 = 0;
    repeat (3) @(negedge clk);

    // Long hold with a pending request, then ack released
    ack = 0; req0 = 1; op0 = 2'b01; a0 = 16'h0F00; b0 = 16'h00F0;
    wait_gnt(0);
    repeat (10) @(negedge clk);
    chk("or_result_held", result, 16'h0FF0);
    ack = 1;
    wait_gnt(0);
    req0 = 0;
    repeat (3) @(negedge clk);

    // Reset during EXEC drops the operation
    ack = 0; req1 = 1; a1 = 16'h00FF; op1 = 2'b11;
    wait_gnt(1);
    rst = 1; req1 = 0;
    @(negedge clk);
    check_zero_outputs("reset_mid_exec");
    rst = 0;
    repeat (2) @(negedge clk);

    // Ack in IDLE is ignored; result waits for a real ack
    ack = 1; @(negedge clk); ack = 0;
    req0 = 1; op0 = 2'b01; a0 = 16'h0F00; b0 = 16'h00F0;
    wait_gnt(0);
    req0 = 0;
    repeat (3) @(negedge clk);
    chk("ack_idle_ignored", {result_valid, result}, {1'b1, 16'h0FF0});
    ack = 1; @(negedge clk);

    // Random traffic; requesters hold operands until granted
    for (int c = 0; c < 3000; c++) begin
      if (req0 && gnt0) begin
        if ($urandom_range(1, 0) == 1) req0 = 0;
        else begin a0 = 16'($urandom); b0 = 16'($urandom); op0 = 2'($urandom); end
      end else if (!req0 && $urandom_range(2, 0) == 0) begin
        req0 = 1; a0 = 16'($urandom); b0 = 16'($urandom); op0 = 2'($urandom);
        if ($urandom_range(7, 0) == 0) b0 = ~a0;
      end
      if (req1 && gnt1) begin
        if ($urandom_range(1, 0) == 1) req1 = 0;
        else begin a1 = 16'($urandom); b1 = 16'($urandom); op1 = 2'($urandom); end
      end else if (!req1 && $urandom_range(2, 0) == 0) begin
        req1 = 1; a1 = 16'($urandom); b1 = 16'($urandom); op1 = 2'($urandom);
        if ($urandom_range(7, 0) == 0) b1 = a1;
      end
      ack = ($urandom_range(3, 0) != 0);
      @(negedge clk);
    end

    req0 = 0; req1 = 0; ack = 1;
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one 16-bit bitwise logic unit (AND/OR/XOR/NOT) between two requesters.
- Round-robin arbitration, operand capture, single-cycle execution, and a result-hold/acknowledge handshake.
- Sits between the lab's operand sources (switch/register front ends) and the result display/register path.
- One transaction in flight at a time.

Parameters:
WIDTH, 16, operand/result width in bits

Ports:
clk  in  1  system clock, rising-edge active
rst  in  1  synchronous, active-high reset
req0  in  1  requester 0 request; held until gnt0 is seen
a0  in  WIDTH  requester 0 operand A
b0  in  WIDTH  requester 0 operand B
op0  in  2  requester 0 opcode
req1  in  1  requester 1 request
a1  in  WIDTH  requester 1 operand A
b1  in  WIDTH  requester 1 operand B
op1  in  2  requester 1 opcode
gnt0  out  1  one-cycle pulse: requester 0 operands captured
gnt1  out  1  one-cycle pulse: requester 1 operands captured
result  out  WIDTH  registered logic result
result_valid  out  1  result holds a valid, unacknowledged value
result_id  out  1  requester that owns result (0/1)
zero_flag  out  1  result == 0, qualified by result_valid
busy  out  1  high whenever state != IDLE
ack  in  1  consumer acknowledges result

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All state and outputs change only on rising clk.
- Reset values: state=IDLE, prio=0, gnt0=gnt1=0, result=0, result_valid=0, result_id=0, zero_flag=0, busy=0.
- Reset applies mid-transaction: the in-flight operation is dropped, no result_valid, no gnt.
- Opcode encoding: 00 A AND B; 01 A OR B; 10 A XOR B; 11 NOT A (B ignored). Bitwise, WIDTH bits, no carry, no sign.
- FSM has three states: IDLE, EXEC, HOLD.
- IDLE:
  - req0/req1 are sampled only in IDLE.
  - If exactly one is high, that requester wins.
  - If both are high, requester == prio wins.
  - At the edge: latch the winner's a/b/op into internal registers, set result_id=winner, assert gnt<winner> for the next cycle only, set prio=~winner, go to EXEC.
  - No request: stay in IDLE.
- EXEC (1 cycle):
  - gnt pulse is visible this cycle.
  - At the edge: result=f(latched A, B, op), zero_flag=(f==0), result_valid=1, go to HOLD.
  - gnt returns to 0.
- HOLD:
  - result, result_id, zero_flag and result_valid are held stable.
  - ack=1 at the edge: result_valid=0, zero_flag=0, go to IDLE.
  - result and result_id keep their last value.
- ack outside HOLD is ignored.
- Requests arriving in EXEC/HOLD are not lost while req stays high; they are evaluated in the next IDLE.
- Latency and throughput:
  - Request sampled at edge N gives gnt high in cycle N..N+1 and result_valid high from edge N+1.
  - With ack tied high: one transaction per 3 cycles; the next sample is at edge N+3.
- Fairness: with both requests continuously high, grants alternate 0,1,0,1,… starting with 0 after reset.
- A single requester is always granted, whatever prio is; prio still toggles to ~winner.
- Requester contract: operand changes after gnt do not affect the captured transaction. If req is still high on return to IDLE, it is a new request.
- busy = (state != IDLE), combinational from state.

Test Plan:
- Reset, then req0 with a0=16'hF0F0, b0=16'hFF00, op0=00 → gnt0 pulse 1 cycle; 1 cycle later result=16'hF000, result_valid=1, result_id=0, zero_flag=0; held until ack.
- req1 with a1=16'h1234, op1=11 (b1 ignored), ack tied 1 → result=16'hEDCB, result_id=1; result_valid high exactly 1 cycle; busy high 2 cycles.
- req0 and req1 held high simultaneously for 4 transactions, op=10, a0=b0=16'hAAAA, a1=16'h5555, b1=16'h0000 → gnt order 0,1,0,1; results 16'h0000 (zero_flag=1), 16'h5555, 16'h0000, 16'h5555.
- HOLD with ack=0 for 10 cycles, then ack=1 → result stable, no gnt issued despite req0 high; after ack the state goes to IDLE and gnt0 appears the cycle after the next sample.
- rst asserted during EXEC → next cycle all outputs 0, state IDLE, prio=0; no result_valid for the aborted op.
- ack pulsed in IDLE with op=01, a0=16'h0F00, b0=16'h00F0 → ack ignored; result 16'h0FF0 then waits in HOLD for a real ack.
